imm_encoder: RTL and testbench
==============================

# imm_encoder

Streaming instruction encoder: the inverse of the immediate generator. It accepts instruction fields and a signed 32-bit immediate over a valid/ready handshake, packs them into a 32-bit RV32 I/load/S/B instruction word, and tags each word with a sequential instruction-memory address. It sits between the testbench or boot program source and the instruction-memory write port, so encoded words decode back through the immediate generator.

## Interface

Parameters:
- ADDR_W, 32, width of the address counter and addr_o
- BASE_ADDR, 0, address given to the first word after reset or clear_i

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- clear_i  in  1  synchronous restart: counter to BASE_ADDR, err_cnt_o to 0
- in_valid_i  in  1  input fields valid
- in_ready_o  out  1  encoder can accept
- fmt_i  in  2  00 I-ALU (0010011), 01 load (0000011), 10 store (0100011), 11 branch (1100011)
- rd_i  in  5  destination register, used by I-ALU and load
- rs1_i  in  5  source 1
- rs2_i  in  5  source 2, used by S and B
- funct3_i  in  3  funct3 field
- imm_i  in  32  signed immediate; byte offset for B
- out_valid_o  out  1  instr_o/addr_o/err_o valid
- out_ready_i  in  1  downstream accepts
- instr_o  out  32  encoded word
- addr_o  out  ADDR_W  address of this word
- err_o  out  1  immediate out of range or misaligned for this word
- err_cnt_o  out  8  saturating count of emitted errored words

## Operation

- Encoding, with imm = imm_i:
  - I-ALU/load: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - rd is ignored for S/B; rs2 is ignored for I-ALU/load.
- Range check (see Configuration):
  - I-ALU/load/S: err when imm_i is outside [-2048, 2047].
  - B: err when imm_i is outside [-4096, 4094] or imm_i[0]=1.
  - An errored word is still emitted, with truncated bits as above.
- Single output register stage:
  - in_ready_o = !out_valid_o || out_ready_i.
  - Input accept = in_valid_i && in_ready_o.
  - On accept: load instr_o, err_o, and addr_o (= current counter); counter += 4.
- Counter wraps modulo 2^ADDR_W.
- err_cnt_o increments on each output transfer (out_valid_o && out_ready_i) with err_o=1; it saturates at 255.
- clear_i:
  - The counter becomes BASE_ADDR.
  - If an input is accepted in the same cycle, that word gets addr BASE_ADDR and the counter becomes BASE_ADDR+4.
  - err_cnt_o becomes 0 (clear wins over a same-cycle increment).
  - The output register and out_valid_o are unaffected.

## Timing

- Reset (rst_i=0, asynchronous):
  - out_valid_o=0, instr_o=0, addr_o=0, err_o=0, err_cnt_o=0.
  - Counter = BASE_ADDR.
  - in_ready_o=1 (combinational from out_valid_o).
- Latency: a word accepted at edge N is visible with out_valid_o=1 after edge N, i.e. one cycle.
- Throughput is one word per cycle while out_ready_i=1.
- Stall: when out_valid_o=1 && out_ready_i=0, all outputs hold stable and in_ready_o=0.
- Simultaneous output transfer and input accept: the new word replaces the old at the same edge, with no bubble.
- out_valid_o drops only after a transfer with no new input accepted.
- Reset asserted mid-stream discards the held word; the next word after release gets BASE_ADDR.

## Configuration

- IMM_ENC_RANGE_CHECK_EN defined:
  - Range/alignment check active; err_o and err_cnt_o behave as above.
- Not defined:
  - No check logic; err_o and err_cnt_o are tied to 0.
  - Out-of-range immediates are silently truncated.
  - Encoding and handshake are unchanged.

## Test plan

- Reset release, one I-ALU word: fmt=00, rd=1, rs1=2, funct3=0, imm=-1 -> one cycle later instr_o=32'hFFF10093, addr_o=0, err_o=0.
- Store then branch back-to-back with out_ready_i=1:
  - S: rs1=2, rs2=3, funct3=2, imm=8 -> 32'h00312423.
  - B: rs1=1, rs2=2, funct3=0, imm=-4 -> 32'hFE208EE3, addr 4.
  - Both decode through the immediate generator to 8 and -2 (imm>>>1 for B).
- Backpressure: hold out_ready_i=0 for 5 cycles with in_valid_i=1 -> in_ready_o=0, outputs stable, no word lost or duplicated; on release, words appear in order with addrs 0, 4, 8.
- Range, with the macro defined:
  - I imm=2048 -> err_o=1, instr_o[31:20]=12'h800.
  - B imm=3 -> err_o=1.
  - After both transfer, err_cnt_o=2; 300 errored words -> err_cnt_o=255.
- clear_i together with an accepted word while the counter is at 0x40 -> that word's addr_o=BASE_ADDR, next word BASE_ADDR+4, err_cnt_o=0.
- Counter wrap with ADDR_W=4, BASE_ADDR=12: successive addrs 12, 0, 4.

Source files
------------

// File: rtl/imm_encoder.sv
`timescale 1ns/1ps
// imm_encoder: packs RV32 I-ALU/load/S/B fields and a signed immediate into an instruction word,
// tagged with a sequential address. Optional range/alignment check: IMM_ENC_RANGE_CHECK_EN.
module imm_encoder #(
    parameter int unsigned              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]        BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        fmt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o
);

    // Handshake: a word moves on a rising edge when valid && ready on that side.
    // in_ready_o is high whenever the output register is empty or being drained this cycle.
    logic              accept;
    logic [31:0]       enc_word;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_addr;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        enc_word = '0;
        case (fmt_i)
            2'b00: enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
            2'b01: enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000011};
            2'b10: enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
            2'b11: enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], 7'b1100011};
            default: enc_word = '0;
        endcase
    end

    // A clear in the accept cycle hands BASE_ADDR to the word being accepted.
    always_comb begin
        base_addr   = clear_i ? BASE_ADDR : cnt_q;
        cnt_d       = base_addr;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            instr_d     = enc_word;
            addr_d      = base_addr;
            cnt_d       = base_addr + ADDR_W'(4);
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q       <= BASE_ADDR;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            addr_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign instr_o     = instr_q;
    assign addr_o      = addr_q;

`ifdef IMM_ENC_RANGE_CHECK_EN
    logic signed [31:0] imm_s;
    logic               rng_err;
    logic               err_q, err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    assign imm_s = imm_i;

    // Branch offsets are byte offsets with an implicit zero LSB, hence the odd check.
    always_comb begin
        rng_err = 1'b0;
        if (fmt_i == 2'b11) begin
            rng_err = (imm_s > 32'sd4094) || (imm_s < -32'sd4096) || imm_i[0];
        end else begin
            rng_err = (imm_s > 32'sd2047) || (imm_s < -32'sd2048);
        end
    end

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            err_d = rng_err;
        end
        if (clear_i) begin
            err_cnt_d = '0;
        end else if (out_valid_q && out_ready_i && err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_i[31:13];
    assign err_o         = 1'b0;
    assign err_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
`timescale 1ns/1ps
// tb_imm_encoder: directed plus random stimulus with a queue scoreboard for imm_encoder,
// alongside a narrow-counter instance (ADDR_W=4, BASE_ADDR=12) that shares the same inputs.
module tb_imm_encoder;

`ifdef IMM_ENC_RANGE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [1:0]  fmt_i = '0;
    logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] imm_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    logic        in_ready_w, out_valid_w, err_w;
    logic [31:0] instr_w;
    logic [3:0]  addr_w;
    logic [7:0]  err_cnt_w;

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk_i(clk), .rst_i(rst_n), .clear_i(clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .fmt_i(fmt_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .imm_i(imm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .instr_o(instr_o), .addr_o(addr_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    imm_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12)) dut_w (
        .clk_i(clk), .rst_i(rst_n), .clear_i(clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_w),
        .fmt_i(fmt_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .imm_i(imm_i),
        .out_valid_o(out_valid_w), .out_ready_i(out_ready_i),
        .instr_o(instr_w), .addr_o(addr_w), .err_o(err_w), .err_cnt_o(err_cnt_w)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
        logic        rng;
        logic [1:0]  fmt;
        logic [31:0] imm;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  expw_q[$];
    logic [31:0] hist_instr[$];
    logic [31:0] hist_addr[$];
    logic        hist_err[$];
    logic [3:0]  histw[$];
    logic [31:0] cnt_m;
    logic [3:0]  cntw_m;
    bit          rand_rdy = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [1:0] f, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [31:0] im);
        case (f)
            2'b00:   return {im[11:0], rs1, f3, rd, 7'h13};
            2'b01:   return {im[11:0], rs1, f3, rd, 7'h03};
            2'b10:   return {im[11:5], rs2, rs1, f3, im[4:0], 7'h23};
            default: return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
        endcase
    endfunction

    function automatic logic range_err(input logic [1:0] f, input logic [31:0] im);
        int signed v;
        v = im;
        if (f == 2'b11) return (v > 4094) || (v < -4096) || im[0];
        return (v > 2047) || (v < -2048);
    endfunction

    // Immediate-generator view of a word, used to confirm encoded words decode back.
    function automatic logic [31:0] dec_imm(input logic [1:0] f, input logic [31:0] w);
        case (f)
            2'b11:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            2'b10:   return {{20{w[31]}}, w[31:25], w[11:7]};
            default: return {{20{w[31]}}, w[31:20]};
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        if (rand_rdy) out_ready_i = 1'($urandom_range(0, 1));
    end

    // Scoreboard: words leaving at the next rising edge are checked just after the falling edge.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL spurious_word observed=%h expected=none", instr_o);
            end else begin
                e = exp_q.pop_front();
                chk("instr", instr_o, e.instr);
                chk("addr", addr_o, e.addr);
                chk("err", 32'(err_o), 32'(e.err));
                if (!e.rng) chk("decode", dec_imm(e.fmt, instr_o), e.imm);
                hist_instr.push_back(instr_o);
                hist_addr.push_back(addr_o);
                hist_err.push_back(err_o);
            end
            chk("w_valid", 32'(out_valid_w), 32'd1);
            if (expw_q.size() != 0) begin
                chk("w_addr", 32'(addr_w), 32'(expw_q[0]));
                histw.push_back(addr_w);
                void'(expw_q.pop_front());
            end
        end
    end

    task automatic send(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] im,
                        input logic clr);
        exp_t e;
        bit   acc;
        int   n;
        fmt_i = f; rd_i = rd; rs1_i = rs1; rs2_i = rs2; funct3_i = f3; imm_i = im;
        clear_i = clr;
        in_valid_i = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            #1;
            acc = in_ready_o;
            if (acc) begin
                e.addr  = clr ? 32'd0 : cnt_m;
                cnt_m   = e.addr + 32'd4;
                expw_q.push_back(clr ? 4'd12 : cntw_m);
                cntw_m  = (clr ? 4'd12 : cntw_m) + 4'd4;
                e.instr = enc(f, rd, rs1, rs2, f3, im);
                e.rng   = range_err(f, im);
                e.err   = CHK_EN && e.rng;
                e.fmt   = f;
                e.imm   = im;
                exp_q.push_back(e);
            end else if (clr) begin
                cnt_m  = 32'd0;
                cntw_m = 4'd12;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted");
        end
        in_valid_i = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid_i = 1'b0;
        clear_i = 1'b0;
        out_ready_i = 1'b1;
        #2;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_errcnt", 32'(err_cnt_o), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        exp_q.delete(); expw_q.delete();
        hist_instr.delete(); hist_addr.delete(); hist_err.delete(); histw.delete();
        cnt_m = 32'd0;
        cntw_m = 4'd12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // First word: one-cycle latency and exact encoding.
        send(2'b00, 5'd1, 5'd2, 5'd9, 3'd0, 32'hFFFF_FFFF, 1'b0);
        chk("lat_valid", 32'(out_valid_o), 32'd1);
        chk("lat_instr", instr_o, 32'hFFF10093);
        drain();
        chk("i_word", hist_instr[0], 32'hFFF10093);
        chk("i_addr", hist_addr[0], 32'd0);

        // Store then branch back-to-back.
        do_reset();
        send(2'b10, 5'd7, 5'd2, 5'd3, 3'd2, 32'd8, 1'b0);
        send(2'b11, 5'd7, 5'd1, 5'd2, 3'd0, -32'sd4, 1'b0);
        drain();
        chk("s_word", hist_instr[0], 32'h00312423);
        chk("b_word", hist_instr[1], 32'hFE208EE3);
        chk("b_addr", hist_addr[1], 32'd4);
        chk("s_dec", dec_imm(2'b10, hist_instr[0]), 32'd8);
        chk("b_dec_half", 32'($signed(dec_imm(2'b11, hist_instr[1])) >>> 1), 32'hFFFF_FFFE);

        // Backpressure: five stalled cycles, then ordered release.
        do_reset();
        out_ready_i = 1'b0;
        fork
            begin
                send(2'b00, 5'd3, 5'd4, 5'd0, 3'd1, 32'd11, 1'b0);
                send(2'b01, 5'd5, 5'd6, 5'd0, 3'd2, 32'd22, 1'b0);
                send(2'b10, 5'd0, 5'd7, 5'd8, 3'd0, 32'd33, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    #1;
                    chk("stall_ready", 32'(in_ready_o), 32'd0);
                    chk("stall_valid", 32'(out_valid_o), 32'd1);
                    chk("stall_instr", instr_o, exp_q[0].instr);
                    chk("stall_addr", addr_o, 32'd0);
                    @(negedge clk);
                end
                out_ready_i = 1'b1;
            end
        join
        drain();
        chk("bp_count", hist_addr.size(), 32'd3);
        chk("bp_addr1", hist_addr[1], 32'd4);
        chk("bp_addr2", hist_addr[2], 32'd8);

        // Range and alignment errors, then saturation of the error count.
        do_reset();
        send(2'b00, 5'd1, 5'd1, 5'd0, 3'd0, 32'd2048, 1'b0);
        send(2'b11, 5'd0, 5'd1, 5'd1, 3'd0, 32'd3, 1'b0);
        drain();
        chk("i2048_hi", 32'(hist_instr[0][31:20]), 32'h800);
        chk("i2048_err", 32'(hist_err[0]), 32'(CHK_EN));
        chk("b_odd_err", 32'(hist_err[1]), 32'(CHK_EN));
        chk("errcnt_2", 32'(err_cnt_o), CHK_EN ? 32'd2 : 32'd0);
        for (int i = 0; i < 300; i++) send(2'b01, 5'd2, 5'd3, 5'd0, 3'd2, 32'd4096, 1'b0);
        drain();
        chk("errcnt_sat", 32'(err_cnt_o), CHK_EN ? 32'd255 : 32'd0);

        // Clear together with an accepted word while the counter sits at 0x40.
        do_reset();
        for (int i = 0; i < 16; i++) send(2'b00, 5'd1, 5'd2, 5'd0, 3'd0, 32'd5000, 1'b0);
        chk("cnt_at_40", cnt_m, 32'h40);
        send(2'b00, 5'd4, 5'd5, 5'd0, 3'd0, 32'd7, 1'b1);
        send(2'b10, 5'd0, 5'd5, 5'd6, 3'd1, -32'sd3, 1'b0);
        drain();
        chk("clr_addr", hist_addr[16], 32'd0);
        chk("clr_next", hist_addr[17], 32'd4);
        chk("clr_errcnt", 32'(err_cnt_o), 32'd0);

        // Narrow counter wraps 12 -> 0 -> 4.
        do_reset();
        for (int i = 0; i < 3; i++) send(2'b00, 5'(i), 5'd1, 5'd0, 3'd0, 32'(i), 1'b0);
        drain();
        chk("wrap0", 32'(histw[0]), 32'd12);
        chk("wrap1", 32'(histw[1]), 32'd0);
        chk("wrap2", 32'(histw[2]), 32'd4);

        // Reset mid-stream drops the held word; the next word restarts at the base address.
        out_ready_i = 1'b0;
        send(2'b00, 5'd9, 5'd9, 5'd0, 3'd0, 32'd99, 1'b0);
        do_reset();
        send(2'b01, 5'd8, 5'd7, 5'd0, 3'd3, 32'd12, 1'b0);
        drain();
        chk("post_rst_addr", hist_addr[0], 32'd0);
        chk("post_rst_count", hist_addr.size(), 32'd1);

        // Random fields and immediates under random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] im;
            im = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 9000)) - 32'd4500;
            send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), im, 1'b0);
        end
        rand_rdy = 1'b0;
        drain();
        chk("final_empty", exp_q.size() + expw_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
